// File: rtl/vote_button_conditioner_pkg.sv
// Shared types and defaults for the vote button front-end.
// States, default sizes and the single-press test used by the conditioner FSM.
package voting_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      COUNT        = 2'd1,
      FIRE         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam int N_BTN_DEFAULT       = 4;
   localparam int HOLD_CYCLES_DEFAULT = 10;

   // True when exactly one bit is set; callers zero-extend narrower vectors.
   function automatic logic pop_is_one(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/vote_button_conditioner_if.sv
// Button/vote bundle between the raw button side and the vote counter stage.
// master drives buttons and mode; slave (the conditioner) drives the vote strobes.
interface vote_button_conditioner_if
   import voting_pkg::*;
#(
   parameter int N_BTN = N_BTN_DEFAULT
);
   logic             mode;
   logic [N_BTN-1:0] button_in;
   logic             vote_valid;
   logic [N_BTN-1:0] vote_onehot;
   logic             vote_reject;
   logic             busy;
   logic             btn_stuck;

   modport master (
      output mode, button_in,
      input  vote_valid, vote_onehot, vote_reject, busy, btn_stuck
   );

   modport slave (
      input  mode, button_in,
      output vote_valid, vote_onehot, vote_reject, busy, btn_stuck
   );
endinterface

// File: rtl/vote_button_conditioner_btn_sync.sv
// Generic-width two-flop synchroniser with asynchronous active-low reset.
module btn_sync #(
   parameter int DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_meta;
   logic [DATA_W-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/vote_button_conditioner.sv
// Debounces the candidate buttons into single-cycle one-hot votes or reject strobes.
// Optional macro STUCK_DETECT_EN adds a sticky stuck-button flag.
module vote_button_conditioner
   import voting_pkg::*;
#(
   parameter int N_BTN        = N_BTN_DEFAULT,
   parameter int HOLD_CYCLES  = HOLD_CYCLES_DEFAULT,
   parameter int STUCK_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   vote_button_conditioner_if.slave  sl
);

   localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(HOLD_CYCLES);

   if (HOLD_CYCLES < 2 || STUCK_CYCLES < 1) begin : g_param_check
      $error("vote_button_conditioner: HOLD_CYCLES must be >= 2 and STUCK_CYCLES >= 1");
   end

   logic [N_BTN-1:0] w_sync_btn;
   logic             w_onehot;

   btn_sync #(.DATA_W(N_BTN)) u_btn_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_d     (sl.button_in),
      .o_q     (w_sync_btn)
   );

   assign w_onehot = pop_is_one(32'(w_sync_btn));

   state_t           r_state,  w_state_nx;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
   logic [N_BTN-1:0] r_cand,   w_cand_nx;
   logic             w_fire;
   logic             w_reject;

   logic             r_vote_valid;
   logic [N_BTN-1:0] r_vote_onehot;
   logic             r_vote_reject;
   logic             r_busy;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cand_nx  = r_cand;
      w_fire     = 1'b0;
      w_reject   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!sl.mode) begin
               if (w_onehot) begin
                  w_cand_nx  = w_sync_btn;
                  w_cnt_nx   = CNT_W'(1);
                  w_state_nx = COUNT;
               end else if (w_sync_btn != '0) begin
                  w_reject   = 1'b1;
                  w_state_nx = WAIT_RELEASE;
               end
            end
         end
         COUNT: begin
            // Display mode aborts a press silently and outranks every button condition.
            if (sl.mode) begin
               w_state_nx = WAIT_RELEASE;
            end else if (w_sync_btn == r_cand) begin
               if (r_cnt >= HOLD_LAST) begin
                  w_fire     = 1'b1;
                  w_state_nx = FIRE;
               end else if (r_cnt != CNT_MAX) begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end else if (w_sync_btn == '0) begin
               w_state_nx = IDLE;
            end else begin
               w_reject   = 1'b1;
               w_state_nx = WAIT_RELEASE;
            end
         end
         FIRE: begin
            w_state_nx = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (w_sync_btn == '0) begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_cand        <= '0;
         r_vote_valid  <= 1'b0;
         r_vote_onehot <= '0;
         r_vote_reject <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_cand        <= w_cand_nx;
         r_vote_valid  <= w_fire;
         r_vote_onehot <= w_fire ? r_cand : '0;
         r_vote_reject <= w_reject;
         r_busy        <= (w_state_nx != IDLE);
      end
   end

   assign sl.vote_valid  = r_vote_valid;
   assign sl.vote_onehot = r_vote_onehot;
   assign sl.vote_reject = r_vote_reject;
   assign sl.busy        = r_busy;

`ifdef STUCK_DETECT_EN
   localparam int                SCNT_W     = $clog2(STUCK_CYCLES + 1);
   localparam logic [SCNT_W-1:0] STUCK_LAST = SCNT_W'(STUCK_CYCLES - 1);
   localparam logic [SCNT_W-1:0] STUCK_MAX  = SCNT_W'(STUCK_CYCLES);

   logic [SCNT_W-1:0] r_stuck_cnt;
   logic              r_btn_stuck;

   // Flag stays set until reset even after the button is finally released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stuck_cnt <= '0;
         r_btn_stuck <= 1'b0;
      end else if (r_state == WAIT_RELEASE) begin
         if (r_stuck_cnt != STUCK_MAX) begin
            r_stuck_cnt <= r_stuck_cnt + 1'b1;
         end
         if (r_stuck_cnt == STUCK_LAST) begin
            r_btn_stuck <= 1'b1;
         end
      end else begin
         r_stuck_cnt <= '0;
      end
   end

   assign sl.btn_stuck = r_btn_stuck;
`else
   assign sl.btn_stuck = 1'b0;
`endif

endmodule
